// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// Each accepted operation is executed once, and its result is held on the response channel until it is consumed.
module alu_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_func,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_func,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_func,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  func_q, func_d;
    logic        id_q, id_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        grant_id;
    logic        accept;

    always_comb begin
        // The pointer only matters when both requesters are contending.
        grant_id   = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        req0_ready = (state_q == IDLE) && req0_valid && !grant_id;
        req1_ready = (state_q == IDLE) && req1_valid && grant_id;
        accept     = req0_ready || req1_ready;

        state_d  = state_q;
        ptr_d    = ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        func_d   = func_q;
        id_d     = id_q;
        result_d = result_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                    a_d     = grant_id ? req1_a : req0_a;
                    b_d     = grant_id ? req1_b : req0_b;
                    func_d  = grant_id ? req1_func : req0_func;
                    id_d    = grant_id;
                end
            end
            EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    ptr_d   = ~id_q;
                end
            end
            default: state_d = IDLE;
        endcase

        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= RR_INIT;
            a_q         <= '0;
            b_q         <= '0;
            func_q      <= '0;
            id_q        <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            func_q      <= func_d;
            id_q        <= id_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_func   = func_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a small reference ALU sits on the shared ALU port.
// Inputs are driven 1 ns after each rising edge, and outputs are sampled 2 ns after each rising edge.
module tb_alu_arbiter;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [3:0]  req0_func;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [3:0]  req1_func;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_func;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [31:0] rsp_result;

    int checks   = 0;
    int failures = 0;

    alu_arbiter #(.RR_INIT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_func  (req0_func),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_func  (req1_func),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_func   (alu_func),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared ALU model.
    always_comb begin
        case (alu_func)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic test_reset;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_func = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_func = '0;
        rsp_ready = 1'b1;
        #2;
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_func !== 4'd0) begin
            failures++; $display("[TB] FAIL reset_alu got=%0h/%0h/%0h exp=0/0/0", alu_a, alu_b, alu_func);
        end
        checks++;
        if (rsp_result !== 32'd0 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_rsp got=%0h/%b/%b exp=0/0/0", rsp_result, rsp_id, rsp_zero);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_func = ALU_ADD;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL add_ready got=%b%b exp=10", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd7 || alu_func !== ALU_ADD) begin
            failures++; $display("[TB] FAIL add_exec got=%b/%0d/%0d/%0d exp=0/5/7/0", rsp_valid, alu_a, alu_b, alu_func);
        end
        @(posedge clk); #2;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd12 || rsp_zero !== 1'b0) begin
            failures++; $display("[TB] FAIL add_rsp got=%b/%b/%0d/%b exp=1/0/12/0", rsp_valid, rsp_id, rsp_result, rsp_zero);
        end
        @(posedge clk); #2;
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_idle got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_sub;
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_func = ALU_SUB;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL sub_ready got=%b%b exp=01", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin
            failures++; $display("[TB] FAIL sub_rsp got=%b/%b/%0d/%b exp=1/1/0/1", rsp_valid, rsp_id, rsp_result, rsp_zero);
        end
        @(posedge clk); #2;
    endtask

    task automatic test_contest;
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'hF0F0; req0_b = 32'h0FF0; req0_func = ALU_AND;
        req1_valid = 1'b1; req1_a = 32'h1;    req1_b = 32'h2;    req1_func = ALU_OR;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL contest_first got=%b%b exp=10", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'h00F0) begin
            failures++; $display("[TB] FAIL contest_rsp0 got=%b/%b/%0h exp=1/0/f0", rsp_valid, rsp_id, rsp_result);
        end
        @(posedge clk); #2;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL contest_second got=%b%b exp=01", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'h3) begin
            failures++; $display("[TB] FAIL contest_rsp1 got=%b/%b/%0h exp=1/1/3", rsp_valid, rsp_id, rsp_result);
        end
        @(posedge clk); #1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL contest_next got=%b%b exp=10", req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_func = ALU_ADD;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_accept got=%b exp=1", req0_ready); end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd1; req1_func = ALU_ADD;
        #1;
        checks++;
        if (req1_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_exec_ready got=%b exp=0", req1_ready); end
        @(posedge clk); #2;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd7 || rsp_zero !== 1'b0 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_hold%0d got=%b/%b/%0d/%b rdy=%b%b exp=1/0/7/0 rdy=00",
                         k, rsp_valid, rsp_id, rsp_result, rsp_zero, req0_ready, req1_ready);
            end
            if (k < 3) begin
                @(posedge clk); #2;
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL bp_release got=%b/%b exp=0/1", rsp_valid, req1_ready);
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_exec;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_func = ALU_SUB;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin failures++; $display("[TB] FAIL rx_accept got=%b exp=1", req0_ready); end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        #1;
        checks++;
        if (alu_a !== 32'd1 || alu_func !== ALU_SUB) begin
            failures++; $display("[TB] FAIL rx_exec got=%0d/%0d exp=1/1", alu_a, alu_func);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_func !== 4'd0 ||
            rsp_result !== 32'd0 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rx_async got=%b/%0h/%0h/%0h/%0h/%b/%b exp=all0",
                     rsp_valid, alu_a, alu_b, alu_func, rsp_result, rsp_id, rsp_zero);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            checks++;
            if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rx_norsp%0d got=%b exp=0", k, rsp_valid); end
        end
    endtask

    task automatic test_back_to_back;
        int grants;
        grants = 0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd1; req0_func = ALU_ADD;
        req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd2; req1_func = ALU_SUB;
        #1;
        for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
            if (req0_ready && req1_ready) begin
                failures++; $display("[TB] FAIL b2b_both_ready cyc=%0d got=11 exp=one-hot", cyc);
            end
            if (req0_ready || req1_ready) begin
                checks++;
                if (req1_ready !== grants[0]) begin
                    failures++; $display("[TB] FAIL b2b_grant%0d got=%b exp=%b", grants, req1_ready, grants[0]);
                end
                grants++;
            end
            @(posedge clk); #2;
        end
        checks++;
        if (grants != 4) begin failures++; $display("[TB] FAIL b2b_timeout got=%0d exp=4 grants", grants); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_contest();
        test_backpressure();
        test_reset_exec();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
